vectored_int_ctrl: RTL

VECTORED_INT_CTRL -- requirements
Module: vectored_int_ctrl

---
 rtl/vectored_int_ctrl_pkg.sv | 14 +
 rtl/vectored_int_ctrl_prio_enc.sv | 26 ++
 rtl/vectored_int_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vectored_int_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM state
// encoding and the default handler-vector layout.
package vectored_int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

endpackage

// File: rtl/vectored_int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: reports the index of the lowest set
// request bit and whether any bit is set at all.
module int_prio_enc #(
  parameter int N = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  output logic [IDW-1:0] id,
  output logic           valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = IDW'(i);
        valid = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller: edge-detects device completion lines into
// a pending register, picks the lowest unmasked pending channel and presents
// its handler address to the CPU, then tracks the handler until eret.
module vectored_int_ctrl
  import vectored_int_ctrl_pkg::*;
#(
  parameter int          NCH        = 4,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
  localparam int         IDW        = $clog2(NCH)
) (
  input  logic           Clk,
  input  logic           reset,
  input  logic [NCH-1:0] done,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_wd,
  input  logic           int_en,
  input  logic           int_ack,
  input  logic           eret,
  output logic           int_req,
  output logic [31:0]    int_addr,
  output logic [IDW-1:0] int_id,
  output logic           epcwrite,
  output logic [NCH-1:0] pending,
  output logic           in_service
);

  state_t           state_r, state_next_s;
  logic [NCH-1:0]   done_d_r;
  logic             armed_r;
  logic [NCH-1:0]   pending_r;
  logic [NCH-1:0]   mask_r;
  logic [IDW-1:0]   id_r;
  logic [31:0]      addr_r;

  logic [NCH-1:0]   masked_s;
  logic [NCH-1:0]   rise_s;
  logic [NCH-1:0]   clr_s;
  logic [IDW-1:0]   enc_id_s;
  logic             enc_valid_s;
  logic             take_s;
  logic             accept_s;

  int_prio_enc #(.N(NCH)) u_prio_enc (
    .req   (masked_s),
    .id    (enc_id_s),
    .valid (enc_valid_s)
  );

  // Request qualification, rising-edge detection and the pending clear mask.
  // armed_r blocks the first edge after reset so a line already high when
  // reset releases is treated as history, not as a new completion.
  always_comb begin
    masked_s = pending_r & ~mask_r;
    rise_s   = armed_r ? (done & ~done_d_r) : '0;
    take_s   = (state_r == ST_IDLE) && int_en && enc_valid_s;
    accept_s = (state_r == ST_REQ) && int_ack;
    if (accept_s) begin
      clr_s = NCH'(1) << id_r;
    end else begin
      clr_s = '0;
    end
  end

  // Done history, pending and mask registers; a new edge beats the clear.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      done_d_r  <= '0;
      armed_r   <= 1'b0;
      pending_r <= '0;
      mask_r    <= '0;
    end else begin
      done_d_r  <= done;
      armed_r   <= 1'b1;
      pending_r <= (pending_r & ~clr_s) | rise_s;
      if (mask_we) begin
        mask_r <= mask_wd;
      end
    end
  end

  // Latch the winning channel and its vector only when a request is taken,
  // so both stay stable through REQ and SERVICE.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      id_r   <= '0;
      addr_r <= VEC_BASE;
    end else if (take_s) begin
      id_r   <= enc_id_s;
      addr_r <= VEC_BASE + (32'(enc_id_s) * VEC_STRIDE);
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; no nesting, a taken request is committed.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_next_s = ST_SERVICE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SERVICE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs; all derive from the state register so reset clears them
  // at once, and epcwrite is the one-cycle accept handshake.
  always_comb begin
    int_req    = (state_r == ST_REQ);
    in_service = (state_r == ST_SERVICE);
    epcwrite   = (state_r == ST_REQ) && int_ack;
    int_id     = id_r;
    int_addr   = addr_r;
    pending    = pending_r;
  end

endmodule
